fir_sequencer: RTL and testbench

- Control and data stage directly upstream of the FIR multiply-accumulate unit.
- Stores incoming decimated samples in a TAPS-deep circular delay line and addresses an external coefficient ROM.
- For each new sample, drives the MAC's clear, write-enable and read-enable strobes, plus both operands, so the MAC produces one filter output per input sample.
- Flags completion with out_strobe; samples that arrive while a convolution is running are flagged with overrun.

---
 rtl/fir_sequencer.sv | 128 ++++++++++++
 tb/tb_fir_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// fir_sequencer: sample delay line plus MAC/ROM sequencing for one FIR output per input sample.
// Every accepted sample is followed by this fixed sequence:
//   CLEAR -> PRIME -> RUN (TAPS cycles) -> FLUSH -> READ -> DONE -> IDLE
module fir_sequencer #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned TAPS   = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [WIDTH-1:0]  sample_in,
  input  logic                     sample_strobe,
  output logic [ADDR_W-1:0]        coeff_addr,
  input  logic signed [WIDTH-1:0]  coeff_data,
  output logic                     mac_clear,
  output logic                     mac_wren,
  output logic                     mac_rden,
  output logic signed [WIDTH-1:0]  mac_m1,
  output logic signed [WIDTH-1:0]  mac_m2,
  output logic                     busy,
  output logic                     out_strobe,
  output logic                     overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_FLUSH = 3'd4,
    S_READ  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q;
  logic [ADDR_W-1:0]        rd_ptr_q;
  logic [ADDR_W-1:0]        tap_q;
  logic signed [WIDTH-1:0]  rd_data_q;
  logic signed [WIDTH-1:0]  mem_q [TAPS];
  logic                     accept;

  // A sample is taken only when the sequencer is idle; anything else is an overrun.
  assign accept = (state_q == S_IDLE) && sample_strobe;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed-length sequence, RUN length set by the tap counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sample_strobe) state_d = S_CLEAR;
      S_CLEAR: state_d = S_PRIME;
      S_PRIME: state_d = S_RUN;
      S_RUN:   if (tap_q == LAST_IDX) state_d = S_FLUSH;
      S_FLUSH: state_d = S_READ;
      S_READ:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Delay line, read pointer walking backwards in time, tap counter and write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tap_q     <= '0;
      rd_data_q <= '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= sample_in;
        rd_ptr_q        <= wr_ptr_q;
      end
      // Read one tap ahead so the registered sample lines up with the ROM's one-cycle latency.
      if ((state_q == S_PRIME) || (state_q == S_RUN)) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - ADDR_W'(1);
      end
      if (state_q == S_RUN) begin
        tap_q <= (tap_q == LAST_IDX) ? '0 : tap_q + ADDR_W'(1);
      end
      if (state_q == S_DONE) begin
        wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + ADDR_W'(1);
      end
    end
  end

  // Output decode from the registered state; operands are forced to zero outside RUN.
  always_comb begin
    coeff_addr = '0;
    mac_clear  = 1'b0;
    mac_wren   = 1'b0;
    mac_rden   = 1'b0;
    mac_m1     = '0;
    mac_m2     = '0;
    out_strobe = 1'b0;
    busy       = (state_q != S_IDLE);
    overrun    = sample_strobe && (state_q != S_IDLE);
    case (state_q)
      S_CLEAR: mac_clear = 1'b1;
      S_PRIME: coeff_addr = '0;
      S_RUN: begin
        mac_wren   = 1'b1;
        mac_m1     = rd_data_q;
        mac_m2     = coeff_data;
        coeff_addr = (tap_q == LAST_IDX) ? '0 : tap_q + ADDR_W'(1);
      end
      S_FLUSH: mac_wren = 1'b1;
      S_READ:  mac_rden = 1'b1;
      S_DONE:  out_strobe = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: drives fir_sequencer with a ROM and pipelined MAC model, scoreboards filter outputs.
module tb_fir_sequencer;

  localparam int unsigned WIDTH  = 24;
  localparam int unsigned TAPS   = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned AW     = 2 * WIDTH;

  logic                     clk = 1'b0;
  logic                     reset;
  logic signed [WIDTH-1:0]  sample_in;
  logic                     sample_strobe;
  logic [ADDR_W-1:0]        coeff_addr;
  logic signed [WIDTH-1:0]  coeff_data = '0;
  logic                     mac_clear, mac_wren, mac_rden;
  logic signed [WIDTH-1:0]  mac_m1, mac_m2;
  logic                     busy, out_strobe, overrun;

  always #5 clk = ~clk;

  fir_sequencer #(.WIDTH(WIDTH), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_strobe(sample_strobe),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .mac_clear(mac_clear), .mac_wren(mac_wren), .mac_rden(mac_rden),
    .mac_m1(mac_m1), .mac_m2(mac_m2),
    .busy(busy), .out_strobe(out_strobe), .overrun(overrun)
  );

  // Coefficient ROM with one-cycle read latency.
  logic signed [WIDTH-1:0] coef [TAPS];
  always @(posedge clk) coeff_data <= coef[coeff_addr];

  // MAC: registered product, accumulator, halved output latch.
  logic signed [AW-1:0] prod, acc, accum_out;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod <= '0; acc <= '0; accum_out <= '0;
    end else begin
      if (mac_clear) begin
        prod <= '0; acc <= '0;
      end else if (mac_wren) begin
        prod <= AW'(mac_m1) * AW'(mac_m2);
        acc  <= acc + prod;
      end
      if (mac_rden) accum_out <= acc >>> 1;
    end
  end

  // Reference filter state and scoreboard.
  longint               dl [TAPS];
  int                   wr;
  logic signed [AW-1:0] q [$];
  int                   total = 0;
  int                   bad = 0;
  int                   n_ostrobe = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) dl[i] = 0;
    wr = 0;
  endtask

  task automatic push_model(input int x);
    longint sum = 0;
    dl[wr] = x;
    for (int k = 0; k < TAPS; k++) sum += dl[(wr - k + TAPS) % TAPS] * longint'(coef[k]);
    q.push_back(AW'(sum >>> 1));
    wr = (wr + 1) % TAPS;
  endtask

  // Falling-edge sample point: pop and compare whenever a result is announced.
  task automatic sample_neg();
    logic signed [AW-1:0] exp;
    @(negedge clk);
    if (out_strobe === 1'b1) begin
      n_ostrobe++;
      if (q.size() > 0) exp = q.pop_front();
      else exp = 'x;
      chk("accum_out", 64'(accum_out), 64'(exp));
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      sample_neg();
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      gap(1); n++;
    end
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  // One-cycle strobe starting now (caller sits just after a rising edge).
  task automatic strobe(input int val, input bit accept_exp, input bit push);
    sample_in = WIDTH'(val);
    sample_strobe = 1'b1;
    sample_neg();
    chk("overrun", 64'(overrun), 64'(!accept_exp));
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    if (accept_exp && push) push_model(val);
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({coeff_addr, mac_clear, mac_wren, mac_rden, mac_m1, mac_m2, busy, out_strobe, overrun});
  endfunction

  task automatic impulse(input string tag);
    int base = n_ostrobe;
    for (int k = 0; k < TAPS; k++) coef[k] = WIDTH'(k + 1);
    gap(20);
    strobe(2, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      gap(20);
      strobe(0, 1'b1, 1'b1);
    end
    drain(tag);
    chk({tag, "_count"}, 64'(n_ostrobe - base), 64'd9);
  endtask

  initial begin
    int clr_cnt, clr_first, wr_cnt, wr_first, wr_last, rd_cnt, rd_first;
    int os_cnt, os_first, busy_cnt, conflict, base;

    reset = 1'b0; sample_strobe = 1'b0; sample_in = '0;
    for (int k = 0; k < TAPS; k++) coef[k] = '0;
    model_reset();
    #1;
    chk("reset_outputs", outs_vec(), 64'd0);
    gap(3);
    reset = 1'b1;

    // Impulse response.
    impulse("impulse");

    // DC step.
    for (int k = 0; k < TAPS; k++) coef[k] = WIDTH'(1000);
    for (int i = 0; i < 9; i++) begin
      gap(20);
      strobe(1000, 1'b1, 1'b1);
    end
    drain("dc");

    // Full-scale operands.
    for (int k = 0; k < TAPS; k++) coef[k] = '0;
    coef[0] = WIDTH'(-8388608);
    gap(20);
    strobe(-8388608, 1'b1, 1'b1);
    gap(20);
    strobe(8388607, 1'b1, 1'b1);
    drain("extremes");

    // Strobe timing of one convolution.
    for (int k = 0; k < TAPS; k++) coef[k] = WIDTH'(3 * k - 7);
    gap(20);
    strobe(5, 1'b1, 1'b1);
    clr_cnt = 0; clr_first = -1; wr_cnt = 0; wr_first = -1; wr_last = -1;
    rd_cnt = 0; rd_first = -1; os_cnt = 0; os_first = -1; busy_cnt = 0; conflict = 0;
    for (int c = 0; c < 16; c++) begin
      sample_neg();
      if (mac_clear) begin clr_cnt++; if (clr_first < 0) clr_first = c; end
      if (mac_wren) begin wr_cnt++; if (wr_first < 0) wr_first = c; wr_last = c; end
      if (mac_rden) begin rd_cnt++; if (rd_first < 0) rd_first = c; end
      if (out_strobe) begin os_cnt++; if (os_first < 0) os_first = c; end
      if (busy) busy_cnt++;
      if ((mac_wren && mac_rden) || (mac_clear && (mac_wren || mac_rden))) conflict++;
      if (c == 1) chk("addr_prime", 64'(coeff_addr), 64'd0);
      if (c >= 2 && c <= 8) chk("addr_run", 64'(coeff_addr), 64'(c - 1));
      @(posedge clk); #1;
    end
    chk("clear_cnt", 64'(clr_cnt), 64'd1);
    chk("clear_pos", 64'(clr_first), 64'd0);
    chk("wren_cnt", 64'(wr_cnt), 64'(TAPS + 1));
    chk("wren_span", 64'(wr_last - wr_first + 1), 64'(TAPS + 1));
    chk("wren_pos", 64'(wr_first), 64'd2);
    chk("rden_cnt", 64'(rd_cnt), 64'd1);
    chk("rden_pos", 64'(rd_first), 64'(TAPS + 3));
    chk("ostrobe_cnt", 64'(os_cnt), 64'd1);
    chk("ostrobe_pos", 64'(os_first), 64'(TAPS + 4));
    chk("busy_cnt", 64'(busy_cnt), 64'(TAPS + 5));
    chk("strobe_conflict", 64'(conflict), 64'd0);
    drain("timing");

    // Strobe during DONE is dropped, strobe in the following cycle is taken.
    gap(20);
    strobe(7, 1'b1, 1'b1);
    gap(TAPS + 4);
    chk("done_state_busy", 64'(busy), 64'd1);
    strobe(99, 1'b0, 1'b0);
    strobe(9, 1'b1, 1'b1);
    drain("done_edge");

    // Ramp with every third strobe landing mid-convolution; delay line wraps.
    for (int k = 0; k < TAPS; k++) coef[k] = WIDTH'(k * k - 5);
    for (int i = 1; i <= 20; i++) begin
      if (i % 3 == 0) begin
        gap(2);
        strobe(i, 1'b0, 1'b0);
      end else begin
        gap(20);
        strobe(i, 1'b1, 1'b1);
      end
    end
    drain("wrap");

    // Reset in the middle of RUN abandons the convolution and clears the delay line.
    gap(20);
    strobe(11, 1'b1, 1'b0);
    gap(5);
    chk("pre_reset_wren", 64'(mac_wren), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrun_reset_outputs", outs_vec(), 64'd0);
    model_reset();
    gap(2);
    reset = 1'b1;
    base = n_ostrobe;
    gap(25);
    chk("no_ostrobe_after_reset", 64'(n_ostrobe), 64'(base));
    impulse("impulse_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
